dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: the processor MEM stage (port 0, "cpu") and a program/data loader or debug master (port 1, "ld").
- Sits between the processor data interface and data_mem. Drives data_mem's address, write-data, length and read/write enables.
- Provides per-port grant, stall and registered acknowledge/read-data.
- Arbitration is two-way round-robin. The loader may lock the memory for bursts. A starvation guard bounds how long the CPU can wait.

Parameters:
- WIDTH, 32, data/address width of requester ports.
- ADDR_W, 8, memory address width; equals $clog2 of data memory size in bytes (256).
- STARVE_MAX, 16, maximum consecutive cycles the CPU may wait while requesting before it is force-granted.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_len  in  3  RISC-V funct3 access length/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
- cpu_addr  in  WIDTH  byte address
- cpu_wdata  in  WIDTH  store data
- cpu_stall  out  1  cpu_req & ~cpu_gnt (combinational)
- cpu_ack  out  1  one-cycle pulse, cycle after grant
- cpu_rdata  out  WIDTH  load data, valid with cpu_ack
- ld_req, ld_we, ld_len, ld_addr, ld_wdata  in  1/1/3/WIDTH/WIDTH  loader request, same meaning as cpu_*
- ld_lock  in  1  loader holds ownership while high
- ld_ack  out  1  one-cycle pulse, cycle after grant
- ld_rdata  out  WIDTH  load data, valid with ld_ack
- mem_addr  out  ADDR_W  granted address, low ADDR_W bits
- mem_in  out  WIDTH  granted write data
- mem_len  out  3  granted length
- mem_read  out  1  granted & ~we
- mem_write  out  1  granted & we
- mem_out  in  WIDTH  memory read data; combinational, same cycle as address

Behaviour:
- Reset (RST=1 at posedge) values:
  - state=ARB, last_gnt=1 (CPU wins the first tie), starve_cnt=0.
  - cpu_ack=ld_ack=0; cpu_rdata=ld_rdata=0.
  - mem_read and mem_write are forced 0 in any cycle where RST=1, so no write commits during reset.
- Grant is combinational from state and requests, with at most one grant per cycle:
  - ARB: only one requester → grant it. Both requesting → grant the port not equal to last_gnt.
  - LOCKED: grant ld whenever ld_req=1. CPU is never granted, except by the starvation override.
  - Starvation override: cpu_req=1 and starve_cnt==STARVE_MAX-1 → grant CPU this cycle in any state.
- Memory drive:
  - mem_* is muxed from the granted port.
  - With no grant, mem_read=mem_write=0 and mem_addr/mem_in/mem_len=0.
- Address width: mem_addr = granted addr[ADDR_W-1:0]. Upper bits are ignored, so out-of-range addresses wrap.
- Response:
  - At the posedge ending the grant cycle, the granted port's ack is set to 1 for exactly one cycle.
  - Its rdata register loads mem_out on reads and holds its previous value on writes.
  - The non-granted port's rdata is unchanged.
  - Latency is 1 cycle from grant to ack.
- Requester rule: a requester keeps its req and fields stable until it sees ack. It may drop req in the ack cycle or issue a new request in that cycle. A new request in the ack cycle is arbitrated normally.
- last_gnt updates to the granted port on every grant.
- State transitions:
  - ARB→LOCKED when ld is granted with ld_lock=1.
  - LOCKED→ARB when ld_lock=0 at a posedge.
  - A starvation grant does not exit LOCKED.
- starve_cnt:
  - Increments each cycle with cpu_req=1 and no CPU grant, saturating at STARVE_MAX-1.
  - Clears on a CPU grant or when cpu_req=0.
- Simultaneous events:
  - Starvation override beats lock and round-robin.
  - RST beats everything.
- LOCKED with ld_req=0 and ld_lock=1: no grant. The CPU still waits, and the starvation guard still applies.

Decomposition:
- Shared package dmem_pkg:
  - Port index constants PORT_CPU=0, PORT_LD=1.
  - Length encodings LEN_B=3'b000, LEN_H=3'b001, LEN_W=3'b010, LEN_BU=3'b100, LEN_HU=3'b101.
  - FSM state encodings ARB and LOCKED.
- Sub-module arb_rr2: two-input round-robin picker.
  - Inputs: req[1:0], last, force0, hold1.
  - Output: one-hot gnt[1:0].
- dmem_arbiter holds the FSM, the counter, the mux and the response registers.

Test Plan:
- Reset then cpu read 0x10 only, mem_out=0x11223344:
  - Grant in the same cycle; mem_addr=0x10, mem_read=1.
  - Next cycle cpu_ack=1, cpu_rdata=0x11223344, cpu_stall=0.
- cpu and ld both request in the same cycle right after reset:
  - CPU is granted first; ld_ack follows one cycle after cpu_ack.
  - Repeating with both requesting gives strictly alternating grants.
- ld write burst of 40 beats (SW, addr 0x00..0x9C step 4) with ld_lock=1 while the CPU requests continuously:
  - CPU is granted on the 16th waiting cycle, then ld resumes.
  - The pattern repeats, and the CPU is never stalled more than 16 cycles.
- ld_lock drops mid-burst:
  - FSM returns to ARB; the next tie goes to the CPU.
- RST asserted in a cycle with the ld write granted (addr 0x20, data 0xDEADBEEF):
  - mem_write=0 that cycle and memory at 0x20 is unchanged.
  - Acks and rdata are 0 after reset.
- cpu_addr=0x0000_0104:
  - mem_addr=0x04 (wrap).
  - A write (SB) leaves cpu_rdata unchanged and pulses cpu_ack.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory arbiter.
// Port indices, funct3 access lengths and arbiter FSM states.
package dmem_pkg;

    localparam int PORT_CPU = 0;
    localparam int PORT_LD  = 1;

    localparam logic [2:0] LEN_B  = 3'b000;
    localparam logic [2:0] LEN_H  = 3'b001;
    localparam logic [2:0] LEN_W  = 3'b010;
    localparam logic [2:0] LEN_BU = 3'b100;
    localparam logic [2:0] LEN_HU = 3'b101;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-input round-robin picker with a CPU force
// and a loader hold.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force0,
    input  logic       hold1,
    output logic [1:0] gnt
);

    // Starvation force first, then lock, then round-robin tie.
    always_comb begin
        gnt = 2'b00;
        priority case (1'b1)
            force0 && req[0]: gnt = 2'b01;
            hold1:            gnt = {req[1], 1'b0};
            req[0] && req[1]: gnt = last ? 2'b01 : 2'b10;
            default:          gnt = req;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data_mem between the CPU MEM stage and a
// loader/debug master, with loader lock and a CPU starvation guard.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 16
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_len,
    input  logic [WIDTH-1:0]  cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_ack,
    output logic [WIDTH-1:0]  cpu_rdata,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [2:0]        ld_len,
    input  logic [WIDTH-1:0]  ld_addr,
    input  logic [WIDTH-1:0]  ld_wdata,
    input  logic              ld_lock,
    output logic              ld_ack,
    output logic [WIDTH-1:0]  ld_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_in,
    output logic [2:0]        mem_len,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [WIDTH-1:0]  mem_out
);

    localparam int CNT_W = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STARVE_MAX - 1);

    arb_state_t       state;
    logic             last_gnt;
    logic [CNT_W-1:0] starve_cnt;
    logic [1:0]       gnt;
    logic             starve_hit;
    logic             locked;
    logic             unused_hi;

    // Address bits above the memory size are ignored so accesses wrap.
    assign unused_hi = ^{cpu_addr[WIDTH-1:ADDR_W],
                         ld_addr[WIDTH-1:ADDR_W]};

    assign starve_hit = cpu_req && (starve_cnt == CNT_TOP);
    assign locked     = (state == LOCKED);

    arb_rr2 u_pick (
        .req    ({ld_req, cpu_req}),
        .last   (last_gnt),
        .force0 (starve_hit),
        .hold1  (locked),
        .gnt    (gnt)
    );

    assign cpu_stall = cpu_req & ~gnt[PORT_CPU];

    // Drive data_mem from the granted port; idle and reset cycles
    // never read or write.
    always_comb begin
        mem_addr  = '0;
        mem_in    = '0;
        mem_len   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (1'b1)
            gnt[PORT_CPU]: begin
                mem_addr  = cpu_addr[ADDR_W-1:0];
                mem_in    = cpu_wdata;
                mem_len   = cpu_len;
                mem_read  = ~cpu_we & ~RST;
                mem_write = cpu_we & ~RST;
            end
            gnt[PORT_LD]: begin
                mem_addr  = ld_addr[ADDR_W-1:0];
                mem_in    = ld_wdata;
                mem_len   = ld_len;
                mem_read  = ~ld_we & ~RST;
                mem_write = ld_we & ~RST;
            end
            default: ;
        endcase
    end

    // Ownership FSM and round-robin history.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ARB;
            last_gnt <= 1'b1;
        end else begin
            if (|gnt)
                last_gnt <= gnt[PORT_LD];
            unique case (state)
                ARB:
                    if (gnt[PORT_LD] && ld_lock)
                        state <= LOCKED;
                LOCKED:
                    if (!ld_lock)
                        state <= ARB;
                default:
                    state <= ARB;
            endcase
        end
    end

    // Count consecutive CPU wait cycles, saturating at the force point.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (cpu_req && !gnt[PORT_CPU]) begin
            if (starve_cnt != CNT_TOP)
                starve_cnt <= starve_cnt + 1'b1;
        end else begin
            starve_cnt <= '0;
        end
    end

    // One-cycle ack and load-data capture for the granted port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cpu_ack   <= 1'b0;
            ld_ack    <= 1'b0;
            cpu_rdata <= '0;
            ld_rdata  <= '0;
        end else begin
            cpu_ack <= gnt[PORT_CPU];
            ld_ack  <= gnt[PORT_LD];
            if (gnt[PORT_CPU] && !cpu_we)
                cpu_rdata <= mem_out;
            if (gnt[PORT_LD] && !ld_we)
                ld_rdata <= mem_out;
        end
    end

endmodule
